alu_pipe_lp: RTL and testbench

//  Parametrised, pipelined integer ALU for the RV32 execute stage.

---
 rtl/alu_pipe_lp.sv | 144 ++++++++++++++
 tb/tb_alu_pipe_lp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_lp.sv
// Pipelined RV32 integer ALU with valid/ready handshake and collapsing bubbles.
// Define LP_OPISO_EN for the operand-isolation low-power build.
module alu_pipe_lp #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [5:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal_op
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_SUB  = 6'b000110;
  localparam logic [5:0] OP_AND  = 6'b000111;
  localparam logic [5:0] OP_OR   = 6'b000101;
  localparam logic [5:0] OP_XOR  = 6'b000001;
  localparam logic [5:0] OP_SLL  = 6'b000100;
  localparam logic [5:0] OP_SRL  = 6'b000011;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_SLT  = 6'b001000;
  localparam logic [5:0] OP_SLTU = 6'b001001;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic             ill;
  } res_t;

`ifdef LP_OPISO_EN
  localparam bit OPISO = 1'b1;
`else
  localparam bit OPISO = 1'b0;
`endif

  // Isolated operands keep the compute cone quiet while no op is presented.
  logic [WIDTH-1:0] a_in, b_in;
  assign a_in = OPISO ? (operand_a & {WIDTH{in_valid}}) : operand_a;
  assign b_in = OPISO ? (operand_b & {WIDTH{in_valid}}) : operand_b;

  logic [WIDTH:0]   sum, dif;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] r;
  logic             c, v, ill;
  res_t             comp;

  assign sum   = {1'b0, a_in} + {1'b0, b_in};
  assign dif   = {1'b0, a_in} - {1'b0, b_in};
  assign shamt = b_in[SHW-1:0];

  always_comb begin
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    ill = 1'b0;
    case (alu_op)
      OP_ADD: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (r[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SUB: begin
        r = dif[WIDTH-1:0];
        c = ~dif[WIDTH];
        v = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (r[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_AND:  r = a_in & b_in;
      OP_OR:   r = a_in | b_in;
      OP_XOR:  r = a_in ^ b_in;
      OP_SLL:  r = a_in << shamt;
      OP_SRL:  r = a_in >> shamt;
      OP_SRA:  r = $signed(a_in) >>> shamt;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, $signed(a_in) < $signed(b_in)};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, a_in < b_in};
      default: ill = 1'b1;
    endcase
    comp = '{result: r, z: ~|r, n: r[WIDTH-1], c: c, v: v, ill: ill};
  end

  // rdy[k]: stage k may load this cycle (empty, or everything downstream moves).
  logic [STAGES-1:0] vld_pipe;
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] v_in;
  res_t              d_in [STAGES];
  res_t              data [STAGES];
  logic              init_done;
  logic              take;

  assign rdy[STAGES] = out_ready;
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign rdy[k] = ~vld_pipe[k] | rdy[k+1];
  end

  assign in_ready = init_done & rdy[0];
  assign take     = in_valid & in_ready;

  always_comb begin
    v_in    = {vld_pipe[STAGES-1:0], take};
    d_in[0] = comp;
    for (int k = 1; k < STAGES; k++) d_in[k] = data[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 0; k < STAGES; k++) data[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_pipe[k] <= v_in[k];
          if (!OPISO || v_in[k]) data[k] <= d_in[k];
        end
      end
    end
  end

  assign out_valid  = vld_pipe[STAGES-1];
  assign alu_result = data[STAGES-1].result;
  assign flag_z     = data[STAGES-1].z;
  assign flag_n     = data[STAGES-1].n;
  assign flag_c     = data[STAGES-1].c;
  assign flag_v     = data[STAGES-1].v;
  assign illegal_op = data[STAGES-1].ill;
endmodule

// File: tb/tb_alu_pipe_lp.sv
// Randomized + directed bench for alu_pipe_lp against an arithmetic reference model.
module tb_alu_pipe_lp;
  localparam int W = 32;
  localparam int S = 2;

  localparam logic [5:0] ADD = 6'b000010, SUB = 6'b000110, AND_ = 6'b000111,
                         OR_ = 6'b000101, XOR_ = 6'b000001, SLL = 6'b000100,
                         SRL = 6'b000011, SRA = 6'b001011, SLT = 6'b001000,
                         SLTU = 6'b001001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand_a, operand_b;
  logic [5:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_result;
  logic         flag_z, flag_n, flag_c, flag_v, illegal_op;

  alu_pipe_lp #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int npop   = 0;
  logic [W+4:0] q[$];
  logic [W+4:0] s_out, held;
  logic acc, seen_out, s_rdy, hold_pending = 1'b0, armed = 1'b0;

  // Reference: signed/unsigned values held in 64-bit integers, truncated at the end.
  function automatic logic [W+4:0] model(input logic [5:0] op, input logic [W-1:0] a, b);
    longint sa, sb, r;
    longint unsigned ua, ub;
    int sh;
    logic c, v, ill;
    logic [W-1:0] res;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    sh = int'(b % 32);
    c = 1'b0; v = 1'b0; ill = 1'b0; r = 0;
    case (op)
      ADD: begin
        r = sa + sb;
        c = (ua + ub) > 64'hFFFF_FFFF;
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      SUB: begin
        r = sa - sb;
        c = ua >= ub;
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      AND_: r = longint'(ua & ub);
      OR_:  r = longint'(ua | ub);
      XOR_: r = longint'(ua ^ ub);
      SLL:  r = longint'(ua << sh);
      SRL:  r = longint'(ua >> sh);
      SRA:  r = sa >>> sh;
      SLT:  r = (sa < sb) ? 64'sd1 : 64'sd0;
      SLTU: r = (ua < ub) ? 64'sd1 : 64'sd0;
      default: ill = 1'b1;
    endcase
    res = r[W-1:0];
    return {res, res == '0, res[W-1], c, v, ill};
  endfunction

  // One clock: called at a negedge, samples 1 unit before the posedge.
  task automatic cycle();
    logic exp_rdy;
    logic [W+4:0] e;
    #4;
    s_out    = {alu_result, flag_z, flag_n, flag_c, flag_v, illegal_op};
    s_rdy    = in_ready;
    seen_out = (out_valid === 1'b1);
    acc      = in_valid && (in_ready === 1'b1);
    exp_rdy  = armed && ((q.size() < S) || out_ready);
    checks++;
    if (in_ready !== exp_rdy) $display("FAIL in_ready: got %b want %b (occ %0d)", in_ready, exp_rdy, q.size());
    else passes++;
    if (hold_pending) begin
      checks++;
      if ({out_valid, s_out} !== {1'b1, held}) $display("FAIL stall_hold: got %b/%h want 1/%h", out_valid, s_out, held);
      else passes++;
    end
    if (seen_out) begin
      checks++;
      if (q.size() == 0) $display("FAIL spurious_out: out_valid with nothing in flight, data %h", s_out);
      else begin
        passes++;
        if (out_ready) begin
          e = q.pop_front();
          npop++;
          checks++;
          if (s_out !== e) $display("FAIL result: got %h want %h", s_out, e);
          else passes++;
        end
      end
    end
    hold_pending = seen_out && !out_ready;
    held = s_out;
    if (acc) q.push_back(model(alu_op, operand_a, operand_b));
    @(posedge clk);
    if (rst_n) armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() > 0; i++) cycle();
    checks++;
    if (q.size() != 0) $display("FAIL drain_timeout: %0d results outstanding, want 0", q.size());
    else passes++;
  endtask

  task automatic send_one(input logic [5:0] op, input logic [W-1:0] a, b,
                          input logic [W+4:0] exp, input string name);
    int lat;
    logic [W+4:0] got;
    out_ready = 1'b1; in_valid = 1'b1;
    alu_op = op; operand_a = a; operand_b = b;
    cycle();
    checks++;
    if (!acc) $display("FAIL %s_accept: got 0 want 1", name);
    else passes++;
    in_valid = 1'b0;
    lat = 0; got = '0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      cycle();
      if (seen_out) begin lat = i; got = s_out; end
    end
    checks++;
    if (lat != S) $display("FAIL %s_latency: got %0d want %0d", name, lat, S);
    else passes++;
    checks++;
    if (got !== exp) $display("FAIL %s: got %h want %h", name, got, exp);
    else passes++;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, in_ready, alu_result, flag_z, flag_n, flag_c, flag_v, illegal_op} !== '0)
      $display("FAIL reset_state: got v=%b r=%b res=%h", out_valid, in_ready, alu_result);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_directed();
    send_one(ADD,  32'd100,       32'd50,        {32'd150,       5'b00000}, "add");
    send_one(SUB,  32'd0,         32'd1,         {32'hFFFFFFFF,  5'b01000}, "sub_neg");
    send_one(ADD,  32'h7FFFFFFF,  32'd1,         {32'h80000000,  5'b01010}, "add_ovf");
    send_one(AND_, 32'hFFFF0000,  32'h0000FFFF,  {32'h0,         5'b10000}, "and");
    send_one(OR_,  32'hFFFF0000,  32'h0000FFFF,  {32'hFFFFFFFF,  5'b01000}, "or");
    send_one(SLL,  32'd1,         32'd5,         {32'h20,        5'b00000}, "sll");
    send_one(SRL,  32'h20,        32'd5,         {32'h1,         5'b00000}, "srl");
    send_one(SRA,  32'h80000000,  32'd31,        {32'hFFFFFFFF,  5'b01000}, "sra");
    send_one(SLL,  32'd1,         32'h25,        {32'h20,        5'b00000}, "sll_mask");
    send_one(SUB,  32'd5,         32'd3,         {32'd2,         5'b00100}, "sub_c");
    send_one(SLT,  32'hFFFFFFFF,  32'd1,         {32'd1,         5'b00000}, "slt");
    send_one(SLTU, 32'hFFFFFFFF,  32'd1,         {32'd0,         5'b10000}, "sltu");
  endtask

  task automatic test_illegal();
    send_one(6'b111111, $urandom, $urandom, {32'd0, 5'b10001}, "illegal");
    send_one(ADD, 32'd1, 32'd2, {32'd3, 5'b00000}, "after_illegal");
  endtask

  task automatic test_back_to_back();
    int sent = 0, base = npop;
    logic saw_full = 1'b0;
    for (int cyc = 0; cyc < 60 && (sent < 8 || q.size() > 0); cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 8);
      alu_op = ADD; operand_a = $urandom; operand_b = $urandom;
      cycle();
      if (acc) sent++;
      if (!s_rdy) saw_full = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (npop - base != 8) $display("FAIL b2b_count: got %0d want 8", npop - base);
    else passes++;
    checks++;
    if (!saw_full) $display("FAIL b2b_full: in_ready never dropped, want 0 seen");
    else passes++;
  endtask

  task automatic test_random();
    logic [5:0] ops[10] = '{ADD, SUB, AND_, OR_, XOR_, SLL, SRL, SRA, SLT, SLTU};
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      alu_op    = ($urandom % 12 == 0) ? 6'(6'h10 | ($urandom % 4 * 16)) : ops[$urandom_range(0, 9)];
      operand_a = ($urandom % 8 == 0) ? 32'h7FFFFFFF : $urandom;
      operand_b = ($urandom % 8 == 0) ? 32'h80000000 : $urandom;
      cycle();
    end
    drain();
  endtask

  task automatic test_lp();
`ifdef LP_OPISO_EN
    send_one(ADD, 32'd11, 32'd22, {32'd33, 5'b00000}, "lp_add");
    for (int i = 0; i < 4; i++) begin
      operand_a = $urandom; operand_b = $urandom;
      cycle();
      checks++;
      if (s_out[W+4:5] !== 32'd33) $display("FAIL lp_bubble_hold: got %h want 00000021", s_out[W+4:5]);
      else passes++;
    end
`endif
  endtask

  task automatic test_reset_inflight();
    int base;
    out_ready = 1'b0; in_valid = 1'b1;
    alu_op = SUB; operand_a = 32'd9; operand_b = 32'd4;
    cycle();
    alu_op = XOR_; operand_a = 32'hA5A5A5A5; operand_b = 32'h0F0F0F0F;
    cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, alu_result, flag_z, flag_n, flag_c, flag_v, illegal_op} !== '0)
      $display("FAIL reset_inflight: got v=%b r=%b res=%h want all 0", out_valid, in_ready, alu_result);
    else passes++;
    q.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b0;
    out_ready = 1'b1;
    base = npop;
    repeat (6) cycle();
    checks++;
    if (npop != base) $display("FAIL reset_stale: got %0d results after reset want 0", npop - base);
    else passes++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; operand_a = '0; operand_b = '0;
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_random();
    test_lp();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
